// File: rtl/mips_loader_pkg.sv
// Shared types and helpers for the MIPS boot/run controller.
// Holds the loader state encoding, the default halt opcode and the byte-lane picker.
package mips_loader_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        IHDR0 = 4'd1,
        IHDR1 = 4'd2,
        IWORD = 4'd3,
        IBYTE = 4'd4,
        DHDR0 = 4'd5,
        DHDR1 = 4'd6,
        DWORD = 4'd7,
        DBYTE = 4'd8,
        DZERO = 4'd9,
        RUN   = 4'd10,
        HALT  = 4'd11,
        TMO   = 4'd12,
        ERR   = 4'd13
    } loader_state_e;

    localparam logic [5:0] DEFAULT_HALT_OP = 6'h3f;
    localparam logic [4:0] SP_REG_IDX      = 5'd29;

    // Byte k of a 32-bit word, k = 0 being the most significant byte.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        case (k)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            2'd3:    return word[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mips_image_loader_serializer.sv
// Turns one 32-bit word into four consecutive big-endian byte writes.
// Shared by the instruction and data phases; the top steers it to one memory port.
module word_byte_serializer
    import mips_loader_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   word_i,
    input  logic [AW-1:0] base_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    byte_o,
    output logic          done_o
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic          busy_r;
    logic [31:0]   word_r;
    logic [AW-1:0] addr_r;
    logic [1:0]    lane_r;

    // Latch a word on start, then walk four byte lanes with incrementing address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r <= 1'b0;
            word_r <= 32'h0000_0000;
            addr_r <= {AW{1'b0}};
            lane_r <= 2'd0;
        end else if (busy_r) begin
            addr_r <= addr_r + ADDR_ONE;
            lane_r <= lane_r + 2'd1;
            if (lane_r == 2'd3) begin
                busy_r <= 1'b0;
            end
        end else if (start_i) begin
            busy_r <= 1'b1;
            word_r <= word_i;
            addr_r <= base_i;
            lane_r <= 2'd0;
        end
    end

    assign we_o   = busy_r;
    assign addr_o = addr_r;
    assign byte_o = byte_lane(word_r, lane_r);
    assign done_o = busy_r & (lane_r == 2'd3);

endmodule

// File: rtl/mips_image_loader.sv
// Boot and run controller: streams instruction and data images into byte memories,
// seeds PC and $sp, then runs the core until halt opcode or cycle-limit timeout.
module mips_image_loader
    import mips_loader_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          IMEM_BYTES = 1024,
    parameter int          DMEM_BYTES = 1024,
    parameter logic [5:0]  HALT_OP    = DEFAULT_HALT_OP,
    parameter int unsigned MAX_CYCLES = 100
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          s_valid_i,
    input  logic [DATA_W-1:0]             s_data_i,
    output logic                          s_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_BYTES)-1:0] imem_addr_o,
    output logic [7:0]                    imem_byte_o,
    output logic                          dmem_we_o,
    output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr_o,
    output logic [7:0]                    dmem_byte_o,
    output logic [DATA_W-1:0]             pc_init_o,
    output logic                          pc_load_o,
    output logic [DATA_W-1:0]             sp_init_o,
    output logic                          sp_load_o,
    output logic                          cpu_run_o,
    input  logic [5:0]                    cpu_instr_op_i,
    output logic [31:0]                   cycle_cnt_o,
    output logic                          halted_o,
    output logic                          timeout_o,
    output logic                          error_o
);

    localparam int IA = $clog2(IMEM_BYTES);
    localparam int DA = $clog2(DMEM_BYTES);
    localparam int AW = (IA > DA) ? IA : DA;
    localparam int EW = DATA_W + 3;

    localparam logic [EW-1:0]     IMEM_LIM = EW'(IMEM_BYTES);
    localparam logic [EW-1:0]     DMEM_LIM = EW'(DMEM_BYTES);
    localparam logic [DA-1:0]     DZ_LAST  = DA'(DMEM_BYTES - 1);
    localparam logic [DA-1:0]     DA_ONE   = {{(DA-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]     STEP4    = AW'(4);
    localparam logic [DATA_W-1:0] W_ZERO   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] W_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam bit                TMO_EN   = (MAX_CYCLES != 0);
    localparam logic [31:0]       CYC_LAST = 32'(MAX_CYCLES) - 32'd1;

    loader_state_e     state_r;
    logic [DATA_W-1:0] pc_init_r;
    logic [DATA_W-1:0] sp_init_r;
    logic              pc_load_r;
    logic              sp_load_r;
    logic [DATA_W-1:0] rem_r;
    logic [AW-1:0]     wbase_r;
    logic [DA-1:0]     zaddr_r;
    logic              zskip_r;
    logic [31:0]       cycle_r;
    logic              halted_r;
    logic              timeout_r;
    logic              error_r;

    logic              xfer_s;
    logic              ser_start_s;
    logic              ser_we_s;
    logic [AW-1:0]     ser_addr_s;
    logic [7:0]        ser_byte_s;
    logic              ser_done_s;
    logic [EW-1:0]     i_end_s;
    logic [EW-1:0]     d_end_s;

    assign s_ready_o   = (state_r == IHDR0) || (state_r == IHDR1) || (state_r == IWORD) ||
                         (state_r == DHDR0) || (state_r == DHDR1) || (state_r == DWORD);
    assign xfer_s      = s_valid_i & s_ready_o;
    assign ser_start_s = xfer_s & ((state_r == IWORD) || (state_r == DWORD));

    // One-past-end byte address of each image; headers are rejected if it exceeds memory.
    assign i_end_s = {3'b000, pc_init_r} + {1'b0, s_data_i, 2'b00};
    assign d_end_s = {1'b0, s_data_i, 2'b00};

    word_byte_serializer #(.AW(AW)) u_ser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (ser_start_s),
        .word_i  (s_data_i[31:0]),
        .base_i  (wbase_r),
        .we_o    (ser_we_s),
        .addr_o  (ser_addr_s),
        .byte_o  (ser_byte_s),
        .done_o  (ser_done_s)
    );

    // Main load/run sequencer with sticky status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            pc_init_r <= W_ZERO;
            sp_init_r <= W_ZERO;
            pc_load_r <= 1'b0;
            sp_load_r <= 1'b0;
            rem_r     <= W_ZERO;
            wbase_r   <= {AW{1'b0}};
            zaddr_r   <= {DA{1'b0}};
            zskip_r   <= 1'b0;
            cycle_r   <= 32'd0;
            halted_r  <= 1'b0;
            timeout_r <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            pc_load_r <= 1'b0;
            sp_load_r <= 1'b0;
            case (state_r)
                IDLE: state_r <= IHDR0;
                IHDR0: if (xfer_s) begin
                    pc_init_r <= s_data_i;
                    pc_load_r <= 1'b1;
                    state_r   <= IHDR1;
                end
                IHDR1: if (xfer_s) begin
                    if ((pc_init_r[1:0] != 2'b00) || (i_end_s > IMEM_LIM)) begin
                        error_r <= 1'b1;
                        state_r <= ERR;
                    end else if (s_data_i == W_ZERO) begin
                        state_r <= DHDR0;
                    end else begin
                        rem_r   <= s_data_i;
                        wbase_r <= AW'(pc_init_r[IA-1:0]);
                        state_r <= IWORD;
                    end
                end
                IWORD: if (xfer_s) begin
                    rem_r   <= rem_r - W_ONE;
                    state_r <= IBYTE;
                end
                IBYTE: if (ser_done_s) begin
                    wbase_r <= wbase_r + STEP4;
                    state_r <= (rem_r == W_ZERO) ? DHDR0 : IWORD;
                end
                DHDR0: if (xfer_s) begin
                    sp_init_r <= s_data_i;
                    sp_load_r <= 1'b1;
                    state_r   <= DHDR1;
                end
                DHDR1: if (xfer_s) begin
                    if (d_end_s > DMEM_LIM) begin
                        error_r <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        rem_r   <= s_data_i;
                        wbase_r <= {AW{1'b0}};
                        zaddr_r <= d_end_s[DA-1:0];
                        zskip_r <= (d_end_s == DMEM_LIM);
                        state_r <= (s_data_i == W_ZERO) ? DZERO : DWORD;
                    end
                end
                DWORD: if (xfer_s) begin
                    rem_r   <= rem_r - W_ONE;
                    state_r <= DBYTE;
                end
                DBYTE: if (ser_done_s) begin
                    wbase_r <= wbase_r + STEP4;
                    if (rem_r != W_ZERO) begin
                        state_r <= DWORD;
                    end else begin
                        state_r <= zskip_r ? RUN : DZERO;
                    end
                end
                DZERO: begin
                    if (zaddr_r == DZ_LAST) begin
                        state_r <= RUN;
                    end else begin
                        zaddr_r <= zaddr_r + DA_ONE;
                    end
                end
                RUN: begin
                    if (cycle_r != 32'hFFFF_FFFF) begin
                        cycle_r <= cycle_r + 32'd1;
                    end
                    // Halt takes priority over a timeout landing on the same edge.
                    if (cpu_instr_op_i == HALT_OP) begin
                        halted_r <= 1'b1;
                        state_r  <= HALT;
                    end else if (TMO_EN && (cycle_r == CYC_LAST)) begin
                        timeout_r <= 1'b1;
                        state_r   <= TMO;
                    end
                end
                HALT, TMO, ERR: state_r <= state_r;
                default: begin
                    error_r <= 1'b1;
                    state_r <= ERR;
                end
            endcase
        end
    end

    assign imem_we_o   = ser_we_s & (state_r == IBYTE);
    assign imem_addr_o = ser_addr_s[IA-1:0];
    assign imem_byte_o = ser_byte_s;
    assign dmem_we_o   = (ser_we_s & (state_r == DBYTE)) | (state_r == DZERO);
    assign dmem_addr_o = (state_r == DZERO) ? zaddr_r : ser_addr_s[DA-1:0];
    assign dmem_byte_o = (state_r == DZERO) ? 8'h00 : ser_byte_s;
    assign pc_init_o   = pc_init_r;
    assign pc_load_o   = pc_load_r;
    assign sp_init_o   = sp_init_r;
    assign sp_load_o   = sp_load_r;
    assign cpu_run_o   = (state_r == RUN);
    assign cycle_cnt_o = cycle_r;
    assign halted_o    = halted_r;
    assign timeout_o   = timeout_r;
    assign error_o     = error_r;

endmodule
